// File: rtl/pnr_classifier.sv
`default_nettype none
// ============================================================================
// Module   : pnr_classifier
// Desc     : Trigger-driven photon-number classifier: delay, windowed peak,
//            threshold count, held result on extension GPIO.
//            Define PNR_PEAK_EN for windowed peak detection; otherwise a
//            single sample is classified.
// Revision : 1.0  initial release
// ============================================================================
module pnr_classifier #(
    parameter int N_LVL    = 7,
    parameter int OUT_HOLD = 16
) (
    input  logic                  ADC_CLK,
    input  logic                  rstn_i,
    input  logic                  trig_i,
    input  logic signed [13:0]    pnr_source_sig,
    input  logic [31:0]           trig_clearance,
    input  logic [31:0]           pnr_delay,
    input  logic [15:0]           pnr_window,
    input  logic [14*N_LVL-1:0]   pnr_thr_flat,
    output logic [7:0]            extension_GPIO_p,
    output logic [7:0]            extension_GPIO_n,
    output logic                  busy_o,
    output logic [31:0]           trig_cnt_o,
    output logic [31:0]           miss_cnt_o
);

    localparam int c_HOLD_W = (OUT_HOLD < 1) ? 1 : $clog2(OUT_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(OUT_HOLD);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_WINDOW = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_clr_cnt;
    logic [31:0]           r_dly_cnt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic signed [13:0]    r_peak;
    logic [31:0]           r_trig_cnt;
    logic [31:0]           r_miss_cnt;
    logic [7:0]            r_gpio_p;
    logic [7:0]            r_gpio_n;
    logic [2:0]            w_count;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_win_last;

`ifdef PNR_PEAK_EN
    logic [15:0]           r_win_cnt;
    logic                  r_first;

    assign w_win_last = (r_win_cnt == 16'd1);
`else
    logic                  w_unused_window;

    assign w_unused_window = ^pnr_window;
    assign w_win_last      = 1'b1;
`endif

    assign w_accept = trig_i && (r_state == S_IDLE) && (r_clr_cnt == 32'd0);
    assign w_reject = trig_i && !w_accept;

    assign busy_o           = (r_state != S_IDLE);
    assign trig_cnt_o       = r_trig_cnt;
    assign miss_cnt_o       = r_miss_cnt;
    assign extension_GPIO_p = r_gpio_p;
    assign extension_GPIO_n = r_gpio_n;

    // Thresholds are read live so late updates still affect the pending result
    always_comb begin
        w_count = 3'd0;
        for (int k = 0; k < N_LVL; k++) begin
            if (r_peak >= $signed(pnr_thr_flat[14*k +: 14])) begin
                w_count = w_count + 3'd1;
            end
        end
    end

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (pnr_delay == 32'd0) ? S_WINDOW : S_DELAY;
                end
            end
            S_DELAY: begin
                if (r_dly_cnt == 32'd1) begin
                    w_state_nxt = S_WINDOW;
                end
            end
            S_WINDOW: begin
                if (w_win_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            r_clr_cnt  <= 32'd0;
            r_dly_cnt  <= 32'd0;
            r_hold_cnt <= '0;
            r_peak     <= '0;
            r_trig_cnt <= 32'd0;
            r_miss_cnt <= 32'd0;
            r_gpio_p   <= 8'd0;
            r_gpio_n   <= 8'd0;
`ifdef PNR_PEAK_EN
            r_win_cnt  <= 16'd0;
            r_first    <= 1'b0;
`endif
        end else begin
            if (r_clr_cnt != 32'd0) begin
                r_clr_cnt <= r_clr_cnt - 32'd1;
            end

            if (w_accept) begin
                r_clr_cnt  <= trig_clearance;
                r_dly_cnt  <= pnr_delay;
                r_trig_cnt <= r_trig_cnt + 32'd1;
`ifdef PNR_PEAK_EN
                r_win_cnt  <= (pnr_window == 16'd0) ? 16'd1 : pnr_window;
                r_first    <= 1'b1;
`endif
            end

            if (w_reject) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end

            case (r_state)
                S_DELAY: begin
                    r_dly_cnt <= r_dly_cnt - 32'd1;
                end
                S_WINDOW: begin
                    r_hold_cnt <= '0;
`ifdef PNR_PEAK_EN
                    // First sample seeds the peak so all-negative pulses classify correctly
                    if (r_first || (pnr_source_sig > r_peak)) begin
                        r_peak <= pnr_source_sig;
                    end
                    r_first   <= 1'b0;
                    r_win_cnt <= r_win_cnt - 16'd1;
`else
                    r_peak <= pnr_source_sig;
`endif
                end
                S_HOLD: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_hold_cnt <= '0;
                        r_gpio_p   <= 8'd0;
                        r_gpio_n   <= 8'd0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                        if (r_hold_cnt == '0) begin
                            r_gpio_p <= 8'd1 << w_count;
                            r_gpio_n <= {4'd0, w_count, 1'b1};
                        end else begin
                            r_gpio_n[0] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pnr_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_pnr_classifier
// Desc     : Directed scoreboard bench for pnr_classifier (either build).
// Revision : 1.0  initial release
// ============================================================================
module tb_pnr_classifier;

    localparam int N_LVL    = 7;
    localparam int OUT_HOLD = 16;

    logic                  ADC_CLK = 1'b0;
    logic                  rstn_i;
    logic                  trig_i;
    logic signed [13:0]    pnr_source_sig;
    logic [31:0]           trig_clearance;
    logic [31:0]           pnr_delay;
    logic [15:0]           pnr_window;
    logic [14*N_LVL-1:0]   pnr_thr_flat;
    logic [7:0]            extension_GPIO_p;
    logic [7:0]            extension_GPIO_n;
    logic                  busy_o;
    logic [31:0]           trig_cnt_o;
    logic [31:0]           miss_cnt_o;

    typedef struct packed {
        int         cyc;
        logic [7:0] p;
        logic [7:0] n;
    } exp_t;

    exp_t sbq[$];
    int   wave[32];
    int   thr[N_LVL];
    int   cyc      = 0;
    int   t_trig   = -1000;
    int   checks   = 0;
    int   failures = 0;
    int   exp_trig = 0;
    int   exp_miss = 0;

    pnr_classifier #(
        .N_LVL    (N_LVL),
        .OUT_HOLD (OUT_HOLD)
    ) dut (
        .ADC_CLK          (ADC_CLK),
        .rstn_i           (rstn_i),
        .trig_i           (trig_i),
        .pnr_source_sig   (pnr_source_sig),
        .trig_clearance   (trig_clearance),
        .pnr_delay        (pnr_delay),
        .pnr_window       (pnr_window),
        .pnr_thr_flat     (pnr_thr_flat),
        .extension_GPIO_p (extension_GPIO_p),
        .extension_GPIO_n (extension_GPIO_n),
        .busy_o           (busy_o),
        .trig_cnt_o       (trig_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    always #5 ADC_CLK = ~ADC_CLK;
    always @(posedge ADC_CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int wave_val(input int i);
        return (i >= 0 && i < 32) ? wave[i] : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance to the next falling edge and present the sample for the coming edge
    task automatic step();
        int off;
        @(negedge ADC_CLK);
        off = cyc + 1 - t_trig;
        pnr_source_sig = 14'(wave_val(off));
    endtask

    task automatic step_to(input int edge_no);
        while (cyc + 1 < edge_no) step();
    endtask

    task automatic fill_wave(input int v);
        for (int i = 0; i < 32; i++) wave[i] = v;
    endtask

    task automatic load_thr();
        for (int k = 0; k < N_LVL; k++) pnr_thr_flat[14*k +: 14] = 14'(thr[k]);
    endtask

    task automatic set_thr_default();
        for (int k = 0; k < N_LVL; k++) thr[k] = 100 * (k + 1);
        load_thr();
    endtask

    task automatic push_expect(input int d, input int w);
        int   eff;
        int   pk;
        int   c;
        exp_t e;
        eff = (w == 0) ? 1 : w;
`ifndef PNR_PEAK_EN
        eff = 1;
`endif
        pk = wave_val(1 + d);
        for (int i = 2; i <= eff; i++) begin
            if (wave_val(d + i) > pk) pk = wave_val(d + i);
        end
        c = 0;
        for (int k = 0; k < N_LVL; k++) begin
            if (pk >= thr[k]) c++;
        end
        e.cyc = t_trig + d + eff + 1;
        e.p   = 8'd1 << c;
        e.n   = {4'd0, 3'(c), 1'b1};
        sbq.push_back(e);
    endtask

    task automatic fire(input bit acc);
        trig_i = 1'b1;
        if (acc) begin
            t_trig = cyc + 1;
            pnr_source_sig = 14'(wave_val(0));
            exp_trig++;
            push_expect(int'(pnr_delay), int'(pnr_window));
        end else begin
            exp_miss++;
        end
        step();
        trig_i = 1'b0;
        if (acc) chk("busy_rise", 32'(busy_o), 32'd1);
    endtask

    task automatic wait_strobe(output exp_t e);
        int n;
        n = 0;
        while (extension_GPIO_n[0] !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("sb_pending", 32'(sbq.size() != 0), 32'd1);
        e = '0;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("result_cycle", 32'(cyc), 32'(e.cyc));
            chk("result_gpio_p", 32'(extension_GPIO_p), 32'(e.p));
            chk("result_gpio_n", 32'(extension_GPIO_n), 32'(e.n));
        end
    endtask

    task automatic check_hold(input exp_t e);
        step();
        chk("strobe_drop_n", 32'(extension_GPIO_n), 32'(e.n & 8'hFE));
        chk("hold_gpio_p", 32'(extension_GPIO_p), 32'(e.p));
        repeat (OUT_HOLD - 2) step();
        chk("hold_last_p", 32'(extension_GPIO_p), 32'(e.p));
        chk("hold_busy", 32'(busy_o), 32'd1);
        step();
        chk("clear_gpio_p", 32'(extension_GPIO_p), 32'd0);
        chk("clear_gpio_n", 32'(extension_GPIO_n), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic run_event();
        exp_t e;
        wait_strobe(e);
        check_hold(e);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_trig_cnt"}, trig_cnt_o, 32'(exp_trig));
        chk({tag, "_miss_cnt"}, miss_cnt_o, 32'(exp_miss));
    endtask

    initial begin
        exp_t e;
        int   t0;
        int   s0;

        rstn_i         = 1'b0;
        trig_i         = 1'b0;
        pnr_source_sig = '0;
        trig_clearance = 32'd0;
        pnr_delay      = 32'd0;
        pnr_window     = 16'd1;
        pnr_thr_flat   = '0;
        set_thr_default();
        fill_wave(0);

        repeat (3) step();
        chk("rst_gpio_p", 32'(extension_GPIO_p), 32'd0);
        chk("rst_gpio_n", 32'(extension_GPIO_n), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        check_counts("rst");
        rstn_i = 1'b1;
        repeat (2) step();

        // Pulse peaking at 350 inside a 4-sample window after delay 5
        pnr_delay = 32'd5; pnr_window = 16'd4;
        fill_wave(0);
        wave[6] = 120; wave[7] = 350; wave[8] = 300; wave[9] = 80;
        fire(1'b1);
        pnr_delay = 32'd1; pnr_window = 16'd2; trig_clearance = 32'd50;
        run_event();
        trig_clearance = 32'd0;
        check_counts("ev_a");

        // Everything below thr[0]
        pnr_delay = 32'd0; pnr_window = 16'd3;
        fill_wave(50);
        fire(1'b1);
        run_event();

        // Full-scale positive sample passes all thresholds
        pnr_delay = 32'd1; pnr_window = 16'd2;
        fill_wave(8191);
        fire(1'b1);
        run_event();

        // Negative peak against a negative lowest threshold
        thr[0] = -8192; thr[1] = -7000;
        load_thr();
        pnr_delay = 32'd3; pnr_window = 16'd5;
        fill_wave(-8000);
        fire(1'b1);
        run_event();
        set_thr_default();

        // Peak arrives at sample 3 of an 8-sample window
        pnr_delay = 32'd2; pnr_window = 16'd8;
        fill_wave(0);
        wave[3] = 150; wave[5] = 650;
        fire(1'b1);
        run_event();

        // Zero window length behaves as one sample
        pnr_delay = 32'd0; pnr_window = 16'd0;
        fill_wave(0);
        wave[1] = 450; wave[2] = 700;
        fire(1'b1);
        run_event();

        // Clearance: reject at T+40 and T+100, accept at T+101
        trig_clearance = 32'd100; pnr_delay = 32'd0; pnr_window = 16'd1;
        fill_wave(250);
        fire(1'b1);
        t0 = t_trig;
        run_event();
        step_to(t0 + 40);
        fire(1'b0);
        check_counts("clr_block");
        step_to(t0 + 100);
        fire(1'b0);
        trig_clearance = 32'd0;
        fire(1'b1);
        chk("clr_accept_t", 32'(t_trig), 32'(t0 + 101));
        run_event();
        check_counts("clr_done");

        // Triggers during HOLD and on the HOLD-to-IDLE edge are rejected
        fill_wave(520);
        fire(1'b1);
        wait_strobe(e);
        s0 = cyc;
        step_to(s0 + 3);
        fire(1'b0);
        step_to(s0 + OUT_HOLD);
        fire(1'b0);
        chk("ret_idle_gpio_p", 32'(extension_GPIO_p), 32'd0);
        chk("ret_idle_busy", 32'(busy_o), 32'd0);
        check_counts("hold_rej");
        fire(1'b1);
        run_event();

        // Asynchronous reset while in WINDOW
        pnr_delay = 32'd2; pnr_window = 16'd8;
        fill_wave(400);
        fire(1'b1);
        step();
        step();
        rstn_i = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_gpio_p", 32'(extension_GPIO_p), 32'd0);
        chk("arst_gpio_n", 32'(extension_GPIO_n), 32'd0);
        sbq.delete();
        exp_trig = 0;
        exp_miss = 0;
        t_trig   = -1000;
        check_counts("arst");
        repeat (2) step();
        rstn_i = 1'b1;
        step();

        pnr_delay = 32'd4; pnr_window = 16'd3;
        fill_wave(0);
        wave[5] = 90; wave[6] = 610; wave[7] = 210;
        fire(1'b1);
        run_event();
        check_counts("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
